hazard_scoreboard: RTL and testbench

Parametrised data-hazard unit for the in-order MIPS pipeline. It sits between ID and EX. It decodes the ID-stage instruction's source and destination registers and tracks in-flight destinations in an internal shift pipe, one entry per downstream stage. Depending on mode it either stalls on any match or returns per-operand forwarding selects, stalling only on load-use. A zero instruction is the bubble, as elsewhere in the pipeline.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/hazard_decode.sv | 64 ++++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: opcodes, the bubble encoding and the
// forwarding-select encoding used by the hazard and forwarding-mux logic.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] BUBBLE = 32'b0;

    // Pipe entry layout: {valid, dest, isLoad}, stored as parallel arrays in the scoreboard
    localparam int MIPS_REG_W = 5;
    localparam int FWD_SEL_W  = 3;

    localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = '0;

endpackage

// File: rtl/hazard_decode.sv
// Combinational operand/destination decode for one instruction; shared by the
// hazard scoreboard and the forwarding-mux control.
module hazard_decode
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  rs_used,
    output logic                  rt_used,
    output logic                  dest_valid,
    output logic                  is_load
);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rdField;
    logic                  hasDest;
    logic                  unusedLowBits;

    assign opcode        = instr[31:26];
    assign rs            = REG_ADDR_W'(instr[25:21]);
    assign rt            = REG_ADDR_W'(instr[20:16]);
    assign rdField       = REG_ADDR_W'(instr[15:11]);
    assign unusedLowBits = ^instr[10:0];

    always_comb begin
        rs_used = 1'b0;
        rt_used = 1'b0;
        hasDest = 1'b0;
        is_load = 1'b0;
        dest    = rt;
        if (instr != BUBBLE) begin
            unique case (opcode)
                OP_RTYPE: begin
                    rs_used = 1'b1;
                    rt_used = 1'b1;
                    hasDest = 1'b1;
                    dest    = rdField;
                end
                OP_LW: begin
                    rs_used = 1'b1;
                    hasDest = 1'b1;
                    is_load = 1'b1;
                end
                OP_SW, OP_BEQ, OP_BNE: begin
                    rs_used = 1'b1;
                    rt_used = 1'b1;
                end
                OP_J: ;
                default: begin
                    rs_used = 1'b1;
                    hasDest = 1'b1;
                end
            endcase
        end
    end

    // $0 is hard-wired, so writing it never creates a dependency
    assign dest_valid = hasDest && (dest != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage data-hazard unit: tracks in-flight destinations per downstream
// stage and produces stall and per-operand forwarding selects.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int FWD_EN      = 1,
    parameter int LOAD_LAT    = 1,
    parameter int STALL_CNT_W = 16,
    parameter int MAX_STALL   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            id_instr,
    input  logic                   flush,
    output logic                   stall,
    output logic [31:0]            id_instr_out,
    output logic [FWD_SEL_W-1:0]   fwd_rs_sel,
    output logic [FWD_SEL_W-1:0]   fwd_rt_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   stall_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);

    logic [REG_ADDR_W-1:0] rs, rt, dest;
    logic                  rsUsed, rtUsed, destValid, isLoad;

    logic [NUM_STAGES-1:0] pipeValid;
    logic [NUM_STAGES-1:0] pipeLoad;
    logic [REG_ADDR_W-1:0] pipeDest [NUM_STAGES];

    logic [NUM_STAGES-1:0] rsHit, rtHit;
    logic [FWD_SEL_W-1:0]  rsFwd, rtFwd;
    logic                  rsLoadUse, rtLoadUse;
    logic                  hazard;
    logic                  passOk;
    logic [RUN_W-1:0]      runCnt;

    hazard_decode #(.REG_ADDR_W(REG_ADDR_W)) decode (
        .instr      (id_instr),
        .rs         (rs),
        .rt         (rt),
        .dest       (dest),
        .rs_used    (rsUsed),
        .rt_used    (rtUsed),
        .dest_valid (destValid),
        .is_load    (isLoad)
    );

    always_comb begin
        rsHit = '0;
        rtHit = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            rsHit[i] = rsUsed && (rs != '0) && pipeValid[i] && (pipeDest[i] == rs);
            rtHit[i] = rtUsed && (rt != '0) && pipeValid[i] && (pipeDest[i] == rt);
        end
    end

    // Scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        rsFwd     = FWD_REGFILE;
        rtFwd     = FWD_REGFILE;
        rsLoadUse = 1'b0;
        rtLoadUse = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (rsHit[i]) begin
                rsFwd     = FWD_SEL_W'(i + 1);
                rsLoadUse = pipeLoad[i] && (i < LOAD_LAT);
            end
            if (rtHit[i]) begin
                rtFwd     = FWD_SEL_W'(i + 1);
                rtLoadUse = pipeLoad[i] && (i < LOAD_LAT);
            end
        end
    end

    assign hazard       = (FWD_EN != 0) ? (rsLoadUse || rtLoadUse) : ((|rsHit) || (|rtHit));
    assign stall        = rst_n && !flush && hazard;
    assign passOk       = rst_n && !flush && !hazard;
    assign id_instr_out = passOk ? id_instr : BUBBLE;
    assign fwd_rs_sel   = (FWD_EN != 0 && passOk) ? rsFwd : FWD_REGFILE;
    assign fwd_rt_sel   = (FWD_EN != 0 && passOk) ? rtFwd : FWD_REGFILE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeValid <= '0;
            pipeLoad  <= '0;
            for (int i = 0; i < NUM_STAGES; i++) pipeDest[i] <= '0;
        end else begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeLoad[i]  <= pipeLoad[i-1];
                pipeDest[i]  <= pipeDest[i-1];
            end
            pipeValid[0] <= passOk && destValid;
            pipeLoad[0]  <= isLoad;
            pipeDest[0]  <= dest;
        end
    end

    // Stall statistics and the consecutive-stall watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            runCnt    <= '0;
            stall_err <= 1'b0;
        end else if (stall) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            if (runCnt != RUN_W'(MAX_STALL)) runCnt <= runCnt + RUN_W'(1);
            if (runCnt >= RUN_W'(MAX_STALL - 1)) stall_err <= 1'b1;
        end else begin
            runCnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stall-only, forwarding and watchdog configurations of the
// hazard scoreboard, each driven by hand-encoded MIPS instruction sequences.
module tb_hazard_scoreboard;

    localparam logic [31:0] ADD_3_1_2   = 32'h0022_1820;
    localparam logic [31:0] SUB_4_3_5   = 32'h0065_2022;
    localparam logic [31:0] OR_6_3_3    = 32'h0063_3025;
    localparam logic [31:0] OR_6_4_4    = 32'h0084_3025;
    localparam logic [31:0] OR_6_10_10  = 32'h014A_3025;
    localparam logic [31:0] LW_8_9      = 32'h8D28_0000;
    localparam logic [31:0] LW_0_9      = 32'h8D20_0000;
    localparam logic [31:0] ADD_10_8_8  = 32'h0108_5020;
    localparam logic [31:0] ADD_11_0_0  = 32'h0000_5820;

    logic clk;
    logic rst_n;

    logic [31:0] instrA, instrB, instrC;
    logic        flushA, flushB, flushC;

    logic        stallA, stallB, stallC;
    logic [31:0] outA, outB, outC;
    logic [2:0]  rsSelA, rtSelA, rsSelB, rtSelB, rsSelC, rtSelC;
    logic [15:0] cntA, cntB;
    logic [1:0]  cntC;
    logic        errA, errB, errC;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.NUM_STAGES(3), .FWD_EN(0)) dutA (
        .clk(clk), .rst_n(rst_n), .id_instr(instrA), .flush(flushA),
        .stall(stallA), .id_instr_out(outA), .fwd_rs_sel(rsSelA), .fwd_rt_sel(rtSelA),
        .stall_cnt(cntA), .stall_err(errA)
    );

    hazard_scoreboard #(.NUM_STAGES(3), .FWD_EN(1), .LOAD_LAT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .id_instr(instrB), .flush(flushB),
        .stall(stallB), .id_instr_out(outB), .fwd_rs_sel(rsSelB), .fwd_rt_sel(rtSelB),
        .stall_cnt(cntB), .stall_err(errB)
    );

    hazard_scoreboard #(.NUM_STAGES(6), .FWD_EN(0), .MAX_STALL(4), .STALL_CNT_W(2)) dutC (
        .clk(clk), .rst_n(rst_n), .id_instr(instrC), .flush(flushC),
        .stall(stallC), .id_instr_out(outC), .fwd_rs_sel(rsSelC), .fwd_rt_sel(rtSelC),
        .stall_cnt(cntC), .stall_err(errC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int dutSel, input logic [31:0] instr, input logic fl);
        instrA = '0; instrB = '0; instrC = '0;
        flushA = 1'b0; flushB = 1'b0; flushC = 1'b0;
        case (dutSel)
            0: begin instrA = instr; flushA = fl; end
            1: begin instrB = instr; flushB = fl; end
            default: begin instrC = instr; flushC = fl; end
        endcase
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, ADD_3_1_2, 1'b0);
        #2;
        checkOutput("rst_stallA", 32'(stallA), 32'd0);
        checkOutput("rst_outA", outA, 32'd0);
        checkOutput("rst_cntA", 32'(cntA), 32'd0);
        checkOutput("rst_errA", 32'(errA), 32'd0);
        checkOutput("rst_rsSelB", 32'(rsSelB), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stall-only mode: RAW on $3 holds sub for three cycles
        applyStimulus(0, ADD_3_1_2, 1'b0);
        checkOutput("A0_stall", 32'(stallA), 32'd0);
        checkOutput("A0_out", outA, ADD_3_1_2);
        nextCycle();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, SUB_4_3_5, 1'b0);
            checkOutput($sformatf("A%0d_stall", i), 32'(stallA), 32'd1);
            checkOutput($sformatf("A%0d_out", i), outA, 32'd0);
            checkOutput($sformatf("A%0d_rsSel", i), 32'(rsSelA), 32'd0);
            nextCycle();
        end
        applyStimulus(0, SUB_4_3_5, 1'b0);
        checkOutput("A4_stall", 32'(stallA), 32'd0);
        checkOutput("A4_out", outA, SUB_4_3_5);
        checkOutput("A4_cnt", 32'(cntA), 32'd3);
        nextCycle();

        // Forwarding mode: back-to-back ALU dependency forwards from EX
        applyStimulus(1, ADD_3_1_2, 1'b0);
        checkOutput("B1_rsSel", 32'(rsSelB), 32'd0);
        nextCycle();
        applyStimulus(1, OR_6_3_3, 1'b0);
        checkOutput("B2_stall", 32'(stallB), 32'd0);
        checkOutput("B2_rsSel", 32'(rsSelB), 32'd1);
        checkOutput("B2_rtSel", 32'(rtSelB), 32'd1);
        nextCycle();
        applyStimulus(1, ADD_3_1_2, 1'b0);
        checkOutput("B3_rsSel", 32'(rsSelB), 32'd0);
        checkOutput("B3_rtSel", 32'(rtSelB), 32'd0);
        nextCycle();
        applyStimulus(1, 32'd0, 1'b0);
        checkOutput("B4_stall", 32'(stallB), 32'd0);
        checkOutput("B4_out", outB, 32'd0);
        nextCycle();
        applyStimulus(1, OR_6_3_3, 1'b0);
        checkOutput("B5_rsSel", 32'(rsSelB), 32'd2);
        checkOutput("B5_rtSel", 32'(rtSelB), 32'd2);
        nextCycle();

        // Load-use: one stall, then forward from MEM
        applyStimulus(1, LW_8_9, 1'b0);
        checkOutput("B6_stall", 32'(stallB), 32'd0);
        checkOutput("B6_out", outB, LW_8_9);
        nextCycle();
        applyStimulus(1, ADD_10_8_8, 1'b0);
        checkOutput("B7_stall", 32'(stallB), 32'd1);
        checkOutput("B7_out", outB, 32'd0);
        checkOutput("B7_rsSel", 32'(rsSelB), 32'd0);
        checkOutput("B7_rtSel", 32'(rtSelB), 32'd0);
        nextCycle();
        applyStimulus(1, ADD_10_8_8, 1'b0);
        checkOutput("B8_stall", 32'(stallB), 32'd0);
        checkOutput("B8_out", outB, ADD_10_8_8);
        checkOutput("B8_rsSel", 32'(rsSelB), 32'd2);
        checkOutput("B8_rtSel", 32'(rtSelB), 32'd2);
        checkOutput("B8_cnt", 32'(cntB), 32'd1);
        nextCycle();
        applyStimulus(1, LW_0_9, 1'b0);
        checkOutput("B9_stall", 32'(stallB), 32'd0);
        nextCycle();
        applyStimulus(1, ADD_11_0_0, 1'b0);
        checkOutput("B10_stall", 32'(stallB), 32'd0);
        checkOutput("B10_out", outB, ADD_11_0_0);
        nextCycle();

        // Flush overrides a pending load-use stall and leaves a bubble in EX
        applyStimulus(1, LW_8_9, 1'b0);
        nextCycle();
        applyStimulus(1, ADD_10_8_8, 1'b1);
        checkOutput("B12_stall", 32'(stallB), 32'd0);
        checkOutput("B12_out", outB, 32'd0);
        nextCycle();
        applyStimulus(1, OR_6_10_10, 1'b0);
        checkOutput("B13_stall", 32'(stallB), 32'd0);
        checkOutput("B13_rsSel", 32'(rsSelB), 32'd0);
        checkOutput("B13_rtSel", 32'(rtSelB), 32'd0);
        checkOutput("B13_cnt", 32'(cntB), 32'd1);
        nextCycle();

        // Watchdog and counter saturation on a six-stage stall-only unit
        applyStimulus(2, ADD_3_1_2, 1'b0);
        checkOutput("C0_stall", 32'(stallC), 32'd0);
        nextCycle();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(2, SUB_4_3_5, 1'b0);
            checkOutput($sformatf("C%0d_stall", i), 32'(stallC), 32'd1);
            checkOutput($sformatf("C%0d_err", i), 32'(errC), (i >= 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("C%0d_cnt", i), 32'(cntC), (i >= 4) ? 32'd3 : 32'(i - 1));
            nextCycle();
        end
        applyStimulus(2, SUB_4_3_5, 1'b0);
        checkOutput("C7_stall", 32'(stallC), 32'd0);
        checkOutput("C7_out", outC, SUB_4_3_5);
        checkOutput("C7_err", 32'(errC), 32'd1);
        nextCycle();
        applyStimulus(2, OR_6_4_4, 1'b0);
        checkOutput("C8_stall", 32'(stallC), 32'd1);

        // Asynchronous reset in the middle of a stall
        rst_n = 1'b0;
        #1;
        checkOutput("C8_rst_stall", 32'(stallC), 32'd0);
        checkOutput("C8_rst_out", outC, 32'd0);
        checkOutput("C8_rst_cnt", 32'(cntC), 32'd0);
        checkOutput("C8_rst_err", 32'(errC), 32'd0);
        #1;
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(2, OR_6_4_4, 1'b0);
        checkOutput("C9_stall", 32'(stallC), 32'd0);
        checkOutput("C9_out", outC, OR_6_4_4);
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
